// File: rtl/wcap_pkg.sv
// Shared types and default sizing for the wcapture video-capture block.
package wcap_pkg;

  localparam int unsigned DefDw    = 8;
  localparam int unsigned DefDepth = 16;
  localparam int unsigned DefXw    = 12;
  localparam int unsigned DefYw    = 12;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StActive
  } wcap_state_e;

endpackage

// File: rtl/wcapture_if.sv
// Consumer-side pixel stream: first-word fall-through head plus pop strobe.
interface wcapture_if
  import wcap_pkg::*;
#(
  parameter int unsigned DW = DefDw
);
  logic          ready;
  logic          dack;
  logic [DW-1:0] dout;
  logic          sof;
  logic          sol;

  modport master (output ready, dout, sof, sol, input dack);
  modport slave  (input ready, dout, sof, sol, output dack);
endinterface

// File: rtl/wcap_fifo.sv
// Power-of-two FIFO with fall-through read; pop when empty is ignored,
// push when full succeeds only if a pop happens in the same cycle.
module wcap_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero while empty so reset shows a clean output.
  assign rdata   = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/wcapture.sv
// Frame/line-synchronised pixel capture into a fall-through FIFO with
// line/frame counters and a sticky overflow flag.
module wcapture
  import wcap_pkg::*;
#(
  parameter int unsigned DW    = DefDw,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned XW    = DefXw,
  parameter int unsigned YW    = DefYw
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          hsync,
  input  logic [DW-1:0] din,
  wcapture_if.master    strm,
  output logic [XW-1:0] xcnt,
  output logic [YW-1:0] ycnt,
  output logic [15:0]   frames,
  output logic          ovf
);
  wcap_state_e   state_q, state_d;
  logic          hsync_q;
  logic          sof_pend_q, sof_pend_d;
  logic          sol_pend_q, sol_pend_d;
  logic [XW-1:0] xcnt_q, xcnt_d;
  logic [YW-1:0] ycnt_q, ycnt_d;
  logic [15:0]   frames_q, frames_d;
  logic          ovf_q, ovf_d;

  logic          active, accept, rise, fall, enter_active, leave_active;
  logic          fifo_full, fifo_empty;
  logic [DW+1:0] fifo_wdata, fifo_rdata;

  assign active       = (state_q == StActive);
  assign accept       = active && hsync && !vsync;
  assign rise         = hsync && !hsync_q;
  assign fall         = !hsync && hsync_q;
  assign enter_active = (state_q == StSync) && !vsync;
  assign leave_active = active && vsync;
  assign fifo_wdata   = {din, sof_pend_q, rise || sol_pend_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (vsync)  state_d = StSync;
      StSync:   if (!vsync) state_d = StActive;
      StActive: if (vsync)  state_d = StSync;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    sof_pend_d = enter_active || (sof_pend_q && !accept);
    sol_pend_d = (rise || sol_pend_q) && !accept;
    // A pixel arriving at a full FIFO is lost unless the consumer pops now.
    ovf_d      = ovf_q || (accept && fifo_full && !strm.dack);
    frames_d   = frames_q + {15'd0, leave_active};

    xcnt_d = xcnt_q;
    if (active && rise) xcnt_d = '0;
    if (accept && (xcnt_d != '1)) xcnt_d = xcnt_d + 1'b1;

    ycnt_d = ycnt_q;
    if (enter_active) begin
      ycnt_d = '0;
    end else if (active && fall && (xcnt_q != '0) && (ycnt_q != '1)) begin
      ycnt_d = ycnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      hsync_q    <= 1'b0;
      sof_pend_q <= 1'b0;
      sol_pend_q <= 1'b0;
      xcnt_q     <= '0;
      ycnt_q     <= '0;
      frames_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hsync_q    <= hsync;
      sof_pend_q <= sof_pend_d;
      sol_pend_q <= sol_pend_d;
      xcnt_q     <= xcnt_d;
      ycnt_q     <= ycnt_d;
      frames_q   <= frames_d;
      ovf_q      <= ovf_d;
    end
  end

  wcap_fifo #(
    .WIDTH(DW + 2),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (pclk),
    .rst  (rst),
    .push (accept),
    .wdata(fifo_wdata),
    .pop  (strm.dack),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign strm.ready                      = !fifo_empty;
  assign {strm.dout, strm.sof, strm.sol} = fifo_rdata;
  assign xcnt                            = xcnt_q;
  assign ycnt                            = ycnt_q;
  assign frames                          = frames_q;
  assign ovf                             = ovf_q;

endmodule

// File: doc/wcapture.md
WCAPTURE -- requirements
Module: wcapture

Interface
REQ-001 Parameter DW, default 8: pixel data width.
REQ-002 Parameter DEPTH, default 16: FIFO entries; power of two, >= 2.
REQ-003 Parameter XW, default 12: pixel-in-line counter width.
REQ-004 Parameter YW, default 12: line-in-frame counter width.
REQ-005 Port pclk  in  1: single clock, all logic rising-edge.
REQ-006 Port rst  in  1: reset, asynchronous, active-high.
REQ-007 Port vsync  in  1: frame sync, high = vertical blanking; synchronous to pclk.
REQ-008 Port hsync  in  1: line valid, high = active pixels; synchronous to pclk.
REQ-009 Port din  in  DW: pixel data, sampled with hsync.
REQ-010 Port ready  out  1: FIFO non-empty; head entry valid on dout/sof/sol.
REQ-011 Port dack  in  1: consumer pop strobe.
REQ-012 Port dout  out  DW: head pixel.
REQ-013 Port sof  out  1: head pixel is first pixel of its frame.
REQ-014 Port sol  out  1: head pixel is first pixel of its line.
REQ-015 Port xcnt  out  XW: pixels accepted in current line.
REQ-016 Port ycnt  out  YW: lines completed in current frame.
REQ-017 Port frames  out  16: completed-frame count.
REQ-018 Port ovf  out  1: sticky overflow flag.

Function
REQ-019 FSM states IDLE, SYNC, ACTIVE; IDLE->SYNC when vsync=1; SYNC->ACTIVE when vsync=0; ACTIVE->SYNC when vsync=1.
REQ-020 Pixel accepted in a cycle iff state=ACTIVE, hsync=1, vsync=0; no capture in IDLE/SYNC (partial first frame discarded).
REQ-021 Accepted pixel written as {din, sof, sol}: sof=1 for first accepted pixel since entering ACTIVE, sol=1 for first accepted pixel since hsync rose.
REQ-022 Write latency: pixel accepted at edge N -> ready=1 and visible on dout from edge N (after update) onward if FIFO was empty.
REQ-023 First-word fall-through: dout/sof/sol always reflect head; undefined-but-stable when ready=0.
REQ-024 dack with ready=1 pops head at that edge; dack with ready=0 ignored, no state change.
REQ-025 Full FIFO, accepted pixel, no pop: pixel dropped, ovf set, held until reset.
REQ-026 Full FIFO, accepted pixel, simultaneous pop: both occur, no drop, ovf unchanged.
REQ-027 Empty FIFO, accepted pixel, dack=1: push only; dack ignored.
REQ-028 Pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-029 xcnt: cleared on hsync rising edge in ACTIVE; +1 per accepted pixel (including dropped); saturates at 2^XW-1.
REQ-030 ycnt: +1 on hsync falling edge in ACTIVE when xcnt>0; saturates at 2^YW-1; cleared on SYNC->ACTIVE.
REQ-031 frames: +1 on ACTIVE->SYNC; wraps modulo 2^16.
REQ-032 vsync rising mid-line: line abandoned, ycnt not incremented, FIFO contents kept.
REQ-033 xcnt/ycnt hold values in SYNC until next SYNC->ACTIVE.

Reset
REQ-034 rst=1 asynchronously forces: state IDLE, FIFO empty, ready=0, sof=0, sol=0, dout=0, xcnt=0, ycnt=0, frames=0, ovf=0.
REQ-035 rst mid-frame discards FIFO contents; after release capture resumes only after next vsync high->low.

Structure
REQ-036 Shared package wcap_pkg holds FSM state enum and default parameter constants.
REQ-037 FIFO storage/pointers SHALL be sub-module wcap_fifo (params WIDTH=DW+2, DEPTH), with push/pop/full/empty ports.

Verification
REQ-038 Reset release, vsync 1->0, line of 4 pixels 0x01..0x04, dack=1 -> pops 0x01(sof=1,sol=1),0x02,0x03,0x04; xcnt=4; ycnt=1 after hsync falls.
REQ-039 Capture 17 pixels into DEPTH=16 with dack=0 -> ready=1, ovf=1, 16 pops return pixels 1..16, pixel 17 absent.
REQ-040 FIFO full, accepted pixel and dack=1 same cycle -> no drop, ovf=0, occupancy stays 16.
REQ-041 Start with vsync=0, hsync active -> nothing captured until vsync pulses; frames=0 until first ACTIVE->SYNC, then 1.
REQ-042 vsync rises after 3 pixels of line 2 -> ycnt stays 1, frames +1, 3 pixels remain poppable, second one sol=0.
REQ-043 Assert rst mid-line with 5 entries queued -> ready=0, all counters 0 immediately, no capture until next vsync fall.
